// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the fetch stage and its IF/ID register.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush and reset load a bubble, stall holds, otherwise loads an instruction or a bubble.
module if_id_reg #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load_valid,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);
  import riscv_pkg::*;

  logic [31:0]     instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_plus4_reg;
  logic            valid_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_reg    <= NOP_INSTR;
      pc_reg       <= '0;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (!stall) begin
      if (load_valid) begin
        instr_reg    <= instr_in;
        pc_reg       <= pc_in;
        pc_plus4_reg <= pc_in + XLEN'(4);
        valid_reg    <= 1'b1;
      end else begin
        instr_reg    <= NOP_INSTR;
        pc_reg       <= '0;
        pc_plus4_reg <= '0;
        valid_reg    <= 1'b0;
      end
    end
  end

  assign instr    = instr_reg;
  assign pc       = pc_reg;
  assign pc_plus4 = pc_plus4_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, variable-latency imem handshake FSM, hold buffer and IF/ID register.
module fetch_stage #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  fetch_stage_if.master     imem,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD
);
  import riscv_pkg::*;

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [31:0]     hold_instr_reg;
  logic            armed_reg;
  logic            req, fire, capture;
  logic            load_valid;
  logic [31:0]     load_instr;

  // armed_reg keeps req low for one cycle after reset so a straggling ack is ignored
  assign req     = (state_reg == FETCH) && armed_reg && !rst;
  assign fire    = req && imem.imem_ack;
  assign capture = fire && !PCSrcE && StallF;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      hold_instr_reg <= NOP_INSTR;
      armed_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      armed_reg <= 1'b1;
      if (capture) begin
        hold_instr_reg <= imem.imem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    unique case (state_reg)
      FETCH: begin
        if (fire) begin
          if (!PCSrcE && StallF) state_next = HOLD;
          if (!PCSrcE && !StallF) pc_next = pc_reg + XLEN'(4);
        end else if (req && PCSrcE) begin
          state_next = DISCARD;
        end
      end
      HOLD: begin
        if (PCSrcE || !StallD) state_next = FETCH;
        if (!PCSrcE && !StallD) pc_next = pc_reg + XLEN'(4);
      end
      DISCARD: begin
        if (imem.imem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    // A redirect always wins, including over a stall or a pending discard
    if (PCSrcE) pc_next = PCTargetE;
  end

  always_comb begin
    load_valid = 1'b0;
    load_instr = NOP_INSTR;
    if (!PCSrcE) begin
      if (fire) begin
        load_valid = 1'b1;
        load_instr = imem.imem_rdata;
      end else if (state_reg == HOLD) begin
        load_valid = 1'b1;
        load_instr = hold_instr_reg;
      end
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall     (StallD),
    .flush     (FlushD),
    .load_valid(load_valid),
    .instr_in  (load_instr),
    .pc_in     (pc_reg),
    .instr     (InstrD),
    .pc        (PCD),
    .pc_plus4  (PCPlus4D),
    .valid     (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stalls/redirects/latency against a program-order scoreboard.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if #(.XLEN(32)) imem_bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (imem_bus),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          idle_cycles = 0;
  bit          live_en = 1'b0;
  bit          rand_lat = 1'b0;
  bit          late_ack = 1'b0;
  int          fixed_lat = 0;
  int          max_lat = 0;
  bit          pending = 1'b0;
  logic [31:0] paddr;
  int          cnt;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // The next instruction to reach Decode after a redirect is the target; everything older is killed
  task automatic redirect(logic [31:0] t);
    PCSrcE    = 1'b1;
    FlushD    = 1'b1;
    PCTargetE = t;
    exp_q.delete();
    exp_q.push_back(t);
  endtask

  task automatic quiet();
    PCSrcE = 1'b0;
    FlushD = 1'b0;
  endtask

  task automatic wait_req(string name, int budget);
    int n;
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(imem_bus.imem_req), 32'd1);
  endtask

  task automatic wait_valid(string name, int budget);
    int n;
    n = 0;
    while (ValidD !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(ValidD), 32'd1);
  endtask

  // Monitor: every newly loaded valid IF/ID entry is the next instruction in program order
  always @(negedge clk) begin
    if (!rst && ValidD && !StallD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h expected none", PCD);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("deliver_pcd", PCD, mon_exp);
        chk("deliver_instrd", InstrD, word_at(mon_exp));
        chk("deliver_pcplus4d", PCPlus4D, mon_exp + 32'd4);
        exp_q.push_back(mon_exp + 32'd4);
        $display("deliver pc=%h instr=%h", PCD, InstrD);
      end
      idle_cycles = 0;
    end else begin
      idle_cycles++;
    end
    if (!live_en) begin
      idle_cycles = 0;
    end else if (idle_cycles > 60) begin
      checks++;
      errors++;
      $display("FAIL liveness: got %0d idle cycles required at most 60", idle_cycles);
      idle_cycles = 0;
    end
  end

  // Instruction memory: one outstanding request, latency in extra cycles, address must hold until ack
  always begin
    @(negedge clk);
    #2;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    if (rst) begin
      pending = 1'b0;
    end else if (late_ack) begin
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      late_ack = 1'b0;
    end else begin
      if (imem_bus.imem_req) begin
        if (!pending) begin
          pending = 1'b1;
          paddr   = imem_bus.imem_addr;
          cnt     = rand_lat ? int'($urandom_range(max_lat, 0)) : fixed_lat;
        end else begin
          chk("addr_stable", imem_bus.imem_addr, paddr);
        end
      end
      if (pending) begin
        if (cnt == 0) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = word_at(paddr);
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    bit s;
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    repeat (2) @(posedge clk);
    step();
    chk("rst_validd", 32'(ValidD), 32'd0);
    chk("rst_instrd", InstrD, NOP_INSTR);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcplus4d", PCPlus4D, 32'd0);
    chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("rst_pcf", imem_bus.imem_addr, RST_PC);

    // Release with a stray ack in the first cycle after reset
    rst = 1'b0; late_ack = 1'b1;
    exp_q.delete(); exp_q.push_back(RST_PC);
    #1;
    chk("post_rst_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    chk("first_req", 32'(imem_bus.imem_req), 32'd1);
    chk("first_addr", imem_bus.imem_addr, RST_PC);

    // Zero-wait memory: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zw_validd", 32'(ValidD), 32'd1);
      chk("zw_pcd", PCD, RST_PC + 32'(4 * i));
    end

    // Ack for 0x10 lands while stalled for three cycles
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req", 32'(imem_bus.imem_req), 32'd0);
      chk("hold_pcd", PCD, 32'h0000_000C);
      chk("hold_instrd", InstrD, word_at(32'h0000_000C));
    end
    StallF = 1'b0; StallD = 1'b0;
    step();
    chk("release_validd", 32'(ValidD), 32'd1);
    chk("release_pcd", PCD, 32'h0000_0010);
    chk("release_instrd", InstrD, word_at(32'h0000_0010));
    chk("release_next_addr", imem_bus.imem_addr, 32'h0000_0014);

    // Two-cycle memory: bubble / instruction alternation
    fixed_lat = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lat2_validd", 32'(ValidD), 32'(i % 2));
      if (i == 0) chk("lat2_addr_held", imem_bus.imem_addr, 32'h0000_0014);
    end

    // Redirect while the request to 0x20 is still outstanding
    fixed_lat = 3;
    step();
    chk("disc_pre_addr", imem_bus.imem_addr, 32'h0000_0020);
    redirect(32'h0000_0100);
    step();
    quiet();
    fixed_lat = 0;
    chk("disc_req", 32'(imem_bus.imem_req), 32'd0);
    chk("disc_validd", 32'(ValidD), 32'd0);
    wait_req("disc_req_resume", 10);
    chk("disc_next_addr", imem_bus.imem_addr, 32'h0000_0100);
    step();
    wait_valid("disc_first_valid", 10);
    chk("disc_first_pcd", PCD, 32'h0000_0100);

    // Redirect and flush in the same cycle as a zero-wait ack
    chk("same_cycle_req", 32'(imem_bus.imem_req), 32'd1);
    redirect(32'h0000_0200);
    step();
    quiet();
    chk("same_cycle_validd", 32'(ValidD), 32'd0);
    chk("same_cycle_instrd", InstrD, NOP_INSTR);
    chk("same_cycle_addr", imem_bus.imem_addr, 32'h0000_0200);
    step();
    chk("same_cycle_pcd", PCD, 32'h0000_0200);

    // PC wrap across the top of the address space
    redirect(32'hFFFF_FFF8);
    step();
    quiet();
    step();
    chk("wrap_pcd_f8", PCD, 32'hFFFF_FFF8);
    step();
    chk("wrap_pcd_fc", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcplus4d", PCPlus4D, 32'h0000_0000);
    step();
    chk("wrap_pcd_0", PCD, 32'h0000_0000);

    // Reset while holding a captured instruction
    StallF = 1'b1; StallD = 1'b1;
    step();
    chk("hold2_req", 32'(imem_bus.imem_req), 32'd0);
    rst = 1'b1;
    step();
    chk("rst_hold_validd", 32'(ValidD), 32'd0);
    chk("rst_hold_pcf", imem_bus.imem_addr, RST_PC);
    chk("rst_hold_req", 32'(imem_bus.imem_req), 32'd0);
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0; late_ack = 1'b1;
    exp_q.delete(); exp_q.push_back(RST_PC);
    #1;
    chk("rst_hold_req_after", 32'(imem_bus.imem_req), 32'd0);
    step();
    chk("rst_hold_req_next", 32'(imem_bus.imem_req), 32'd1);
    chk("rst_hold_addr_next", imem_bus.imem_addr, RST_PC);
    step();
    chk("rst_hold_first_pcd", PCD, RST_PC);

    // Randomized stalls, redirects and memory latency
    rand_lat = 1'b1; max_lat = 3; live_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      quiet();
      s = ($urandom_range(4, 0) == 0);
      StallF = s; StallD = s;
      if ($urandom_range(24, 0) == 0) redirect($urandom() & 32'hFFFF_FFFC);
    end
    step();
    quiet(); StallF = 1'b0; StallD = 1'b0;
    repeat (10) step();
    live_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, comprising the PC register, instruction-memory request handshake and IF/ID pipeline register.
- It is the consumer of the hazard unit's StallF, StallD and FlushD outputs and of the branch/jump redirect (PCSrcE, PCTargetE) from Execute.
- It tolerates variable-latency instruction memory by inserting bubbles and discarding stale responses.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- StallF  input  1  hold PCF; no PC advance.
- StallD  input  1  hold IF/ID register contents.
- FlushD  input  1  replace IF/ID contents with a bubble.
- PCSrcE  input  1  taken branch/jump redirect from Execute.
- PCTargetE  input  XLEN  redirect target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address (= PCF).
- imem_ack  input  1  response valid this cycle; completes the request.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- InstrD  output  32  decode-stage instruction.
- PCD  output  XLEN  decode-stage PC.
- PCPlus4D  output  XLEN  PCD+4.
- ValidD  output  1  1 = InstrD is a real instruction, 0 = bubble.

Behaviour:
- Reset, synchronous on clk when rst=1:
  - PCF=RESET_PC, state=FETCH, imem_req=0 in the reset cycle.
  - InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0.
  - Reset mid-transaction abandons any outstanding request. Memory is required to drop it; a late ack in the first cycle after reset is ignored.
- Handshake:
  - imem_req=1 only in FETCH.
  - imem_addr=PCF, held stable until ack.
  - ack may arrive in the same cycle as req (zero-wait) or any later cycle.
  - At most one request is outstanding.
- States:
  - FETCH: request outstanding or about to issue.
  - HOLD: instruction captured in the hold buffer while stalled; req=0.
  - DISCARD: redirect taken while a request was outstanding; req=0; wait for the ack and drop its data.
- Cycle priority, highest first: rst > PCSrcE > FlushD > StallF/StallD > normal.
- PCSrcE=1:
  - PCF<=PCTargetE.
  - If in FETCH with ack=1 this cycle, the data is dropped and the state stays FETCH (new request next cycle, not the same cycle).
  - If in FETCH with ack=0, go to DISCARD.
  - If in HOLD, the buffer is invalidated and the state goes to FETCH.
  - PCSrcE overrides StallF.
- DISCARD + ack: go to FETCH; the request to the new PCF starts the next cycle. PCSrcE in DISCARD updates PCF and stays in DISCARD.
- FlushD=1: IF/ID loads NOP, ValidD=0 (overrides StallD).
- FETCH + ack + no stall:
  - IF/ID loads InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
  - PCF<=PCF+4; stay in FETCH.
- FETCH + ack + StallF: capture rdata/PCF into the hold buffer; go to HOLD; PCF unchanged.
- HOLD + StallD=0:
  - IF/ID loads from the buffer (ValidD=1).
  - PCF<=PCF+4; go to FETCH.
- FETCH + no ack + StallD=0: IF/ID loads a bubble (NOP, ValidD=0).
- StallD=1 without FlushD: IF/ID holds all fields unchanged.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- StallF and StallD are always asserted together by the hazard unit. The block does not have to handle them differing.

Decomposition:
- riscv_pkg holds:
  - XLEN.
  - NOP_INSTR=32'h0000_0013.
  - Fetch state encoding FETCH/HOLD/DISCARD (2 bits).
- One sub-module, if_id_reg: the IF/ID register with stall/flush/load and reset-to-bubble.
- PC register, FSM and hold buffer live in fetch_stage.

Test Plan:
- Zero-wait memory (ack same cycle as req), no hazards -> after reset PCD takes 0,4,8,12 on consecutive cycles, ValidD=1 each cycle, PCPlus4D=PCD+4.
- Memory with 2-cycle latency -> InstrD alternates real/bubble (ValidD 1,0,1,0), and imem_addr is stable while req is pending.
- ack at PCF=0x10 while StallF=StallD=1 for 3 cycles -> IF/ID is unchanged and req=0 during HOLD. When the stall drops, InstrD=word@0x10, PCD=0x10, and the next req has addr=0x14.
- PCSrcE=1 with PCTargetE=0x100 while a request to 0x20 is outstanding -> enters DISCARD and the late ack data never reaches InstrD. The next req has addr=0x100, and the first valid PCD is 0x100.
- PCSrcE and ack in the same cycle, with FlushD=1 -> ValidD=0, InstrD=0x00000013, the fetched word is dropped, and the next req has addr=PCTargetE.
- rst asserted while in HOLD -> the next cycle shows PCF=RESET_PC, ValidD=0, req=0, then a request to RESET_PC the cycle after. PC at 0xFFFFFFFC advances to 0x00000000.
